// File: rtl/soc_bb_ext_pkg.sv
// soc_bb_ext_pkg: shared access types, latency limits and counter constants
// for the Blackbone external-port responder.
package soc_bb_ext_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE} acc_e;

    localparam int          RD_LAT_MIN = 1;
    localparam int          RD_LAT_MAX = 4;
    localparam logic [31:0] CNT_SAT    = 32'hFFFF_FFFF;

    function automatic acc_e acc_decode(input logic en, input logic [1:0] we);
        return !en ? IDLE : (we == 2'b00) ? READ : WRITE;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_SAT) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/soc_bb_ext_ram.sv
// soc_bb_ext_ram: single-port RAM, one-cycle synchronous read, byte write enables.
module soc_bb_ext_ram #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [1:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en && i_we[0]) r_mem[i_addr][7:0] <= i_din[7:0];
        if (i_en && i_we[1]) r_mem[i_addr][15:8] <= i_din[15:8];
        if (i_en && i_we == 2'b00) r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/soc_bb_ext_responder.sv
// soc_bb_ext_responder: Blackbone external-port memory with configurable read latency.
// Define SOC_BB_EXT_STATS_EN to enable the access counters and sticky range-error flag.
module soc_bb_ext_responder
    import soc_bb_ext_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bb_ext_addr_i,
    input  logic [DATA_WIDTH-1:0] bb_ext_din_i,
    input  logic                  bb_ext_en_i,
    input  logic [1:0]            bb_ext_we_i,
    output logic [DATA_WIDTH-1:0] bb_ext_dout_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic [31:0]           rd_cnt_o,
    output logic [31:0]           wr_cnt_o
);

    localparam int              RAM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_lat_chk
        $error("READ_LATENCY out of range");
    end

    acc_e                    w_acc;
    logic                    w_oor;
    logic [DATA_WIDTH-1:0]   w_ram_q;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_tail;
    logic [READ_LATENCY-1:0] r_vld;
    logic                    r_oor;
    logic [DATA_WIDTH-1:0]   r_dout;

    assign w_acc = acc_decode(bb_ext_en_i, bb_ext_we_i);
    assign w_oor = (w_acc != IDLE) && ({1'b0, bb_ext_addr_i} >= DEPTH_W);

    soc_bb_ext_ram #(
        .AW    (RAM_AW),
        .DW    (DATA_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .i_en   ((w_acc != IDLE) && !w_oor),
        .i_we   (bb_ext_we_i),
        .i_addr (bb_ext_addr_i[RAM_AW-1:0]),
        .i_din  (bb_ext_din_i),
        .o_dout (w_ram_q)
    );

    // Out-of-range reads never touch the RAM; their slot carries zero instead.
    assign w_head = r_oor ? '0 : w_ram_q;

    if (READ_LATENCY == 1) begin : g_lat1
        assign w_tail = w_head;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] r_dat [READ_LATENCY-1];
        always_ff @(posedge clk) begin
            r_dat[0] <= w_head;
            for (int i = 1; i < READ_LATENCY - 1; i++) r_dat[i] <= r_dat[i-1];
        end
        assign w_tail = r_dat[READ_LATENCY-2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= '0;
            r_oor  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_vld <= (r_vld << 1) | READ_LATENCY'(w_acc == READ);
            r_oor <= w_oor;
            if (r_vld[READ_LATENCY-1]) r_dout <= w_tail;
        end
    end

    assign bb_ext_dout_o = r_dout;

`ifdef SOC_BB_EXT_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic        r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_acc == READ) r_rd_cnt <= sat_inc(r_rd_cnt);
            if (w_acc == WRITE) r_wr_cnt <= sat_inc(r_wr_cnt);
            r_err <= w_oor ? 1'b1 : err_clr_i ? 1'b0 : r_err;
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
    assign err_o    = r_err;
`else
    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
    // Clear input is accepted but has no effect without statistics.
    assign err_o    = err_clr_i & 1'b0;
`endif

endmodule

// File: doc/soc_bb_ext_responder.md
SOC_BB_EXT_RESPONDER -- requirements
Module: soc_bb_ext_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-address width of the Blackbone external port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width; fixed at two bytes.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, number of implemented words; must be no more than 2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from read request to data; legal values are 1 to 4.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port bb_ext_addr_i, input, ADDR_WIDTH bits: word address from the tile.
REQ-008 SHALL have port bb_ext_din_i, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port bb_ext_en_i, input, 1 bit: access strobe, one access per asserted cycle.
REQ-010 SHALL have port bb_ext_we_i, input, 2 bits: byte write enables, where bit 1 covers [15:8]; 2'b00 with en high means a read.
REQ-011 SHALL have port bb_ext_dout_o, output, DATA_WIDTH bits: read data returned to the tile.
REQ-012 SHALL have port err_o, output, 1 bit: sticky flag for an out-of-range access.
REQ-013 SHALL have port err_clr_i, input, 1 bit: clears err_o.
REQ-014 SHALL have port rd_cnt_o, output, 32 bits: count of accepted reads.
REQ-015 SHALL have port wr_cnt_o, output, 32 bits: count of accepted writes.

Function
REQ-016 SHALL treat a cycle with en=1 and we=00 as a read, and a cycle with en=1 and we!=00 as a write; cycles with en=0 are idle.
REQ-017 SHALL accept one access every cycle, with no backpressure and no wait states.
REQ-018 SHALL perform a write in its accept cycle, updating only the bytes whose enable bit is set.
REQ-019 SHALL present read data on dout exactly READ_LATENCY cycles after the accept edge, through a valid-tagged shift pipeline.
REQ-020 SHALL hold dout at the last completed read value until the next read completes; idle cycles and writes leave dout unchanged.
REQ-021 SHALL return the new data when a read to the same address follows a write in the next cycle (write-then-read coherence).
REQ-022 SHALL, when a read and an earlier in-flight read are pipelined back-to-back, deliver each in order on consecutive cycles.
REQ-023 SHALL treat an access with addr >= MEM_DEPTH as out of range: a read returns 0 at normal latency, a write is dropped, and err_o is set on the next edge.
REQ-024 SHALL clear err_o on the edge after err_clr_i=1; if set and clear occur in the same cycle, set wins.
REQ-025 SHALL increment rd_cnt_o and wr_cnt_o once per accepted access, including out-of-range ones, and saturate at 32'hFFFF_FFFF.

Reset
REQ-026 SHALL, while rst=0, force dout to 0, err_o to 0, both counters to 0, and clear all pipeline valid bits.
REQ-027 SHALL discard reads in flight when reset asserts mid-operation; they never appear on dout.
REQ-028 SHALL leave memory contents uninitialised and not clear them on reset.
REQ-029 SHALL treat the first edge after reset release as a normal accept cycle.

Configuration
REQ-030 SHALL, with SOC_BB_EXT_STATS_EN defined, implement rd_cnt_o, wr_cnt_o, err_o and err_clr_i as specified above.
REQ-031 SHALL, with SOC_BB_EXT_STATS_EN undefined, tie rd_cnt_o, wr_cnt_o and err_o to 0, ignore err_clr_i, and keep all data-path behaviour unchanged.

Structure
REQ-032 SHALL place the access-type enum (IDLE, READ, WRITE), the READ_LATENCY limits and the counter saturation constant in shared package soc_bb_ext_pkg.
REQ-033 SHALL instantiate the storage as sub-module soc_bb_ext_ram: single-port RAM, one-cycle synchronous read, byte write enables.
REQ-034 SHALL keep the latency pipeline, range check and statistics logic in soc_bb_ext_responder.

Verification
REQ-035 SHALL cover: write 16'hA5C3 to addr 5 with we=11, then read addr 5 at READ_LATENCY=1 -> dout=16'hA5C3 one cycle after the read.
REQ-036 SHALL cover: addr 5 holds 16'hA5C3, write 16'h7700 with we=10, then read -> dout=16'h77C3.
REQ-037 SHALL cover: READ_LATENCY=3, reads of addrs 1, 2 and 3 on consecutive cycles -> the three values appear on cycles 3, 4 and 5 in order, and dout holds afterwards.
REQ-038 SHALL cover: read addr 4096 with MEM_DEPTH=4096 -> dout=0 and err_o=1; err_clr_i and a new out-of-range access in the same cycle -> err_o stays 1.
REQ-039 SHALL cover: a read accepted, then rst=0 one cycle later -> dout=0, the read is never delivered, and counters are 0.
REQ-040 SHALL cover: rd_cnt preloaded near 32'hFFFF_FFFE by force, then three reads -> rd_cnt_o=32'hFFFF_FFFF; with the macro undefined -> counters and err_o stay 0.
